// File: rtl/snitch_acc_issue.sv
// ============================================================================
// Module      : snitch_acc_issue
// Description : Core-side acc initiator. Tags offloads with table IDs, matches
//               out-of-order responses back to rd, tracks busy registers.
//               Optional perf counters: define SNITCH_ACC_ISSUE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snitch_acc_issue #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  off_valid_i,
  output logic                                  off_ready_o,
  input  logic [31:0]                           off_addr_i,
  input  logic [31:0]                           off_op_i,
  input  logic [DataWidth-1:0]                  off_arga_i,
  input  logic [DataWidth-1:0]                  off_argb_i,
  input  logic [DataWidth-1:0]                  off_argc_i,
  input  logic [4:0]                            off_rd_i,
  output logic                                  acc_qvalid_o,
  input  logic                                  acc_qready_i,
  output logic [31:0]                           acc_qaddr_o,
  output logic [IdWidth-1:0]                    acc_qid_o,
  output logic [31:0]                           acc_qdata_op_o,
  output logic [DataWidth-1:0]                  acc_qdata_arga_o,
  output logic [DataWidth-1:0]                  acc_qdata_argb_o,
  output logic [DataWidth-1:0]                  acc_qdata_argc_o,
  input  logic                                  acc_pvalid_i,
  output logic                                  acc_pready_o,
  input  logic [IdWidth-1:0]                    acc_pid_i,
  input  logic [DataWidth-1:0]                  acc_pdata_i,
  input  logic                                  acc_perror_i,
  output logic                                  wb_valid_o,
  input  logic                                  wb_ready_i,
  output logic [4:0]                            wb_rd_o,
  output logic [DataWidth-1:0]                  wb_data_o,
  output logic                                  wb_error_o,
  output logic [31:0]                           rd_busy_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  idle_o,
  output logic                                  spurious_o
`ifdef SNITCH_ACC_ISSUE_PERF_EN
  ,
  input  logic                                  perf_clear_i,
  output logic [31:0]                           perf_issued_o,
  output logic [31:0]                           perf_stall_o,
  output logic [15:0]                           perf_spurious_o
`endif
);

  localparam int unsigned c_idx_w = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned c_cnt_w = $clog2(MaxOutstanding + 1);

  logic [MaxOutstanding-1:0] r_valid;
  logic [4:0]                r_rd [MaxOutstanding];
  logic [31:0]               r_busy, w_busy_nxt;
  logic                      r_qvalid;
  logic                      r_wb_valid;
  logic [4:0]                r_wb_rd;
  logic [c_idx_w-1:0]        r_wb_id;
  logic [c_cnt_w-1:0]        r_cnt;
  logic                      r_spurious;

  logic                      w_free, w_hit, w_waw, w_issue, w_release, w_phs;
  logic [c_idx_w-1:0]        w_alloc_idx, w_hit_idx;

  // Lowest-index free entry wins; scan downwards so the last hit is the lowest.
  always_comb begin
    w_free      = 1'b0;
    w_alloc_idx = '0;
    for (int i = int'(MaxOutstanding) - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free      = 1'b1;
        w_alloc_idx = c_idx_w'(i);
      end
    end
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (acc_pid_i == IdWidth'(i) && r_valid[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
    end
  end

  assign w_waw        = (off_rd_i != 5'd0) && r_busy[off_rd_i];
  assign off_ready_o  = w_free && (!r_qvalid || acc_qready_i) && !w_waw;
  assign w_issue      = off_valid_i && off_ready_o;
  assign acc_pready_o = !r_wb_valid || wb_ready_i;
  assign w_phs        = acc_pvalid_i && acc_pready_o;
  assign w_release    = r_wb_valid && wb_ready_i;

  // Entries stay allocated until their writeback is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) r_rd[i] <= '0;
    end else begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (w_issue && w_alloc_idx == c_idx_w'(i)) begin
          r_valid[i] <= 1'b1;
          r_rd[i]    <= off_rd_i;
        end else if (w_release && r_wb_id == c_idx_w'(i)) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_release) w_busy_nxt[r_wb_rd] = 1'b0;
    if (w_issue)   w_busy_nxt[off_rd_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_issue, w_release})
        2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
        2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Request stage: reloads in the same cycle it drains for full throughput.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_qvalid         <= 1'b0;
      acc_qaddr_o      <= '0;
      acc_qid_o        <= '0;
      acc_qdata_op_o   <= '0;
      acc_qdata_arga_o <= '0;
      acc_qdata_argb_o <= '0;
      acc_qdata_argc_o <= '0;
    end else if (w_issue) begin
      r_qvalid         <= 1'b1;
      acc_qaddr_o      <= off_addr_i;
      acc_qid_o        <= IdWidth'(w_alloc_idx);
      acc_qdata_op_o   <= off_op_i;
      acc_qdata_arga_o <= off_arga_i;
      acc_qdata_argb_o <= off_argb_i;
      acc_qdata_argc_o <= off_argc_i;
    end else if (acc_qready_i) begin
      r_qvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_id    <= '0;
      wb_data_o  <= '0;
      wb_error_o <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_spurious <= w_phs && !w_hit;
      if (w_phs && w_hit) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd[w_hit_idx];
        r_wb_id    <= w_hit_idx;
        wb_data_o  <= acc_pdata_i;
        wb_error_o <= acc_perror_i;
      end else if (wb_ready_i) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign acc_qvalid_o  = r_qvalid;
  assign wb_valid_o    = r_wb_valid;
  assign wb_rd_o       = r_wb_rd;
  assign rd_busy_o     = r_busy;
  assign outstanding_o = r_cnt;
  assign spurious_o    = r_spurious;
  assign idle_o        = (r_cnt == '0) && !r_qvalid && !r_wb_valid;

`ifdef SNITCH_ACC_ISSUE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o   <= '0;
      perf_stall_o    <= '0;
      perf_spurious_o <= '0;
    end else if (perf_clear_i) begin
      perf_issued_o   <= '0;
      perf_stall_o    <= '0;
      perf_spurious_o <= '0;
    end else begin
      if (w_issue)                     perf_issued_o   <= perf_issued_o + 32'd1;
      if (off_valid_i && !off_ready_o) perf_stall_o    <= perf_stall_o + 32'd1;
      if (w_phs && !w_hit)             perf_spurious_o <= perf_spurious_o + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_snitch_acc_issue.sv
// ============================================================================
// Module      : tb_snitch_acc_issue
// Description : Scoreboard bench for snitch_acc_issue (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snitch_acc_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        off_valid = 1'b0, off_ready;
  logic [31:0] off_addr = '0, off_op = '0, off_arga = '0, off_argb = '0, off_argc = '0;
  logic [4:0]  off_rd = '0;
  logic        acc_qvalid, acc_qready = 1'b1;
  logic [31:0] acc_qaddr, acc_qop, acc_qa, acc_qb, acc_qc;
  logic [4:0]  acc_qid;
  logic        acc_pvalid = 1'b0, acc_pready;
  logic [4:0]  acc_pid = '0;
  logic [31:0] acc_pdata = '0;
  logic        acc_perror = 1'b0;
  logic        wb_valid, wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_error;
  logic [31:0] rd_busy;
  logic [2:0]  outstanding;
  logic        idle, spurious;

  snitch_acc_issue #(.DataWidth(32), .IdWidth(5), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .off_valid_i(off_valid), .off_ready_o(off_ready), .off_addr_i(off_addr),
    .off_op_i(off_op), .off_arga_i(off_arga), .off_argb_i(off_argb),
    .off_argc_i(off_argc), .off_rd_i(off_rd),
    .acc_qvalid_o(acc_qvalid), .acc_qready_i(acc_qready), .acc_qaddr_o(acc_qaddr),
    .acc_qid_o(acc_qid), .acc_qdata_op_o(acc_qop), .acc_qdata_arga_o(acc_qa),
    .acc_qdata_argb_o(acc_qb), .acc_qdata_argc_o(acc_qc),
    .acc_pvalid_i(acc_pvalid), .acc_pready_o(acc_pready), .acc_pid_i(acc_pid),
    .acc_pdata_i(acc_pdata), .acc_perror_i(acc_perror),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .wb_error_o(wb_error),
    .rd_busy_o(rd_busy), .outstanding_o(outstanding), .idle_o(idle),
    .spurious_o(spurious)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference tag table
  typedef struct { int id; logic [4:0] rd; logic [31:0] data; logic err; } sb_t;
  sb_t        sb_q[$];
  sb_t        sb_e;
  bit         m_valid[4];
  logic [4:0] m_rd[4];

  function automatic int m_alloc();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_rd[i] != 5'd0) b[m_rd[i]] = 1'b1;
    return b;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 4; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Writeback monitor: pops the scoreboard, frees the model entry at the handshake edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        sb_e = sb_q.pop_front();
        chk("wb_rd", wb_rd, sb_e.rd);
        chk("wb_data", wb_data, sb_e.data);
        chk("wb_error", wb_error, sb_e.err);
        @(posedge clk);
        if (rst_n) m_valid[sb_e.id] = 1'b0;
      end
    end
  end

  task automatic offload(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         output int id, output int waited);
    logic [31:0] bz;
    logic        exp_rdy;
    off_valid = 1'b1; off_rd = rd; off_arga = a; off_argb = b; off_argc = a ^ b;
    off_op = 32'h0000_002B | {20'd0, rd, 7'd0}; off_addr = 32'h0000_0001 + {27'd0, rd};
    waited = 0;
    forever begin
      #1;
      id = m_alloc();
      bz = m_busy();
      exp_rdy = (id >= 0) && !(rd != 5'd0 && bz[rd]);
      if (acc_qready) chk("off_ready", off_ready, exp_rdy);
      if (off_ready) break;
      waited++;
      if (waited > 200) begin
        chk("offload_timeout", 0, 1);
        off_valid = 1'b0;
        return;
      end
      tick();
    end
    tick();
    off_valid = 1'b0;
    if (id >= 0) begin
      m_valid[id] = 1'b1;
      m_rd[id] = rd;
    end
    chk("q_valid", acc_qvalid, 1);
    chk("q_id", acc_qid, id);
    chk("q_addr", acc_qaddr, 32'h1 + rd);
    chk("q_op", acc_qop, 32'h2B | (rd << 7));
    chk("q_arga", acc_qa, a);
    chk("q_argb", acc_qb, b);
    chk("q_argc", acc_qc, a ^ b);
    chk("rd_busy", rd_busy, m_busy());
    chk("outstanding", outstanding, m_cnt());
  endtask

  task automatic respond(input int id, input logic [31:0] data, input logic err);
    bit hit;
    int w = 0;
    acc_pvalid = 1'b1; acc_pid = 5'(id); acc_pdata = data; acc_perror = err;
    forever begin
      #1;
      if (acc_pready) break;
      w++;
      if (w > 200) begin
        chk("resp_timeout", 0, 1);
        acc_pvalid = 1'b0;
        return;
      end
      tick();
    end
    hit = (id < 4) && m_valid[id];
    if (hit) sb_q.push_back('{id, m_rd[id], data, err});
    tick();
    acc_pvalid = 1'b0;
    chk("spurious_pulse", spurious, !hit);
    if (!hit) begin
      tick();
      chk("spurious_clear", spurious, 0);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!idle && w < 100) begin tick(); w++; end
    chk("idle", idle, 1);
    chk("idle_busy", rd_busy, 0);
    chk("idle_outstanding", outstanding, 0);
  endtask

  task automatic check_reset_values();
    chk("rst_qvalid", acc_qvalid, 0);
    chk("rst_wbvalid", wb_valid, 0);
    chk("rst_qid", acc_qid, 0);
    chk("rst_qarga", acc_qa, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_spurious", spurious, 0);
    chk("rst_idle", idle, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, w, id13, id14;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Single op
    offload(5'd5, 32'd3, 32'd4, id, w);
    chk("single_id", id, 0);
    chk("single_busy5", rd_busy[5], 1);
    repeat (3) tick();
    respond(0, 32'h0000_000C, 1'b0);
    wait_idle();

    // Fill the table, 5th offload waits for a release then reuses the freed ID
    for (int k = 1; k <= 4; k++) begin
      offload(5'(k), 32'(k), 32'(k * 2), id, w);
      chk("fill_id", id, k - 1);
    end
    chk("fill_peak", outstanding, 4);
    fork
      offload(5'd6, 32'h66, 32'h77, id, w);
      begin repeat (3) tick(); respond(2, 32'hF2, 1'b0); end
    join
    chk("fill_reuse_id", id, 2);
    chk("fill_stalled", w >= 4, 1);
    respond(0, 32'hF0, 1'b0);
    respond(3, 32'hF3, 1'b1);
    respond(1, 32'hF1, 1'b0);
    respond(2, 32'hF6, 1'b0);
    wait_idle();

    // WAW on rd=7, and rd=0 never stalls
    offload(5'd7, 32'h7, 32'h70, id, w);
    fork
      offload(5'd7, 32'h8, 32'h80, id, w);
      begin repeat (2) tick(); respond(0, 32'h700, 1'b0); end
    join
    chk("waw_stalled", w >= 4, 1);
    offload(5'd0, 32'h1, 32'h2, id, w);
    chk("rd0_nostall_a", w, 0);
    offload(5'd0, 32'h3, 32'h4, id, w);
    chk("rd0_nostall_b", w, 0);
    respond(2, 32'hB0, 1'b0);
    respond(0, 32'h701, 1'b0);
    respond(1, 32'hA0, 1'b0);
    wait_idle();

    // Out-of-order responses
    for (int k = 0; k < 3; k++) begin
      offload(5'(10 + k), 32'(k), 32'(k), id, w);
      chk("ooo_id", id, k);
    end
    respond(2, 32'hC12, 1'b0);
    respond(0, 32'hC10, 1'b0);
    respond(1, 32'hC11, 1'b1);
    wait_idle();

    // Request and writeback backpressure
    acc_qready = 1'b0;
    offload(5'd13, 32'hDEAD_0013, 32'hBEEF_0013, id13, w);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_qvalid", acc_qvalid, 1);
      chk("bp_qid", acc_qid, id13);
      chk("bp_qarga", acc_qa, 32'hDEAD_0013);
      chk("bp_qop", acc_qop, 32'h2B | (13 << 7));
    end
    acc_qready = 1'b1;
    tick();
    chk("bp_qdrained", acc_qvalid, 0);
    offload(5'd14, 32'h14, 32'h41, id14, w);
    wb_ready = 1'b0;
    respond(id13, 32'hD13, 1'b0);
    tick();
    chk("bp_pready_low", acc_pready, 0);
    chk("bp_wb_held", wb_valid, 1);
    fork
      respond(id14, 32'hD14, 1'b0);
      begin repeat (4) tick(); wb_ready = 1'b1; end
    join
    wait_idle();

    // Spurious responses
    respond(3, 32'h333, 1'b0);
    chk("spur_no_wb", wb_valid, 0);
    respond(9, 32'h999, 1'b0);
    chk("spur_no_wb_oor", wb_valid, 0);

    // Reset mid-flight, then a late response is spurious
    offload(5'd20, 32'h20, 32'h2, id, w);
    offload(5'd21, 32'h21, 32'h3, id, w);
    wb_ready = 1'b0;
    respond(0, 32'h2020, 1'b0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    check_reset_values();
    tick();
    wb_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    respond(1, 32'h2121, 1'b0);
    chk("post_rst_no_wb", wb_valid, 0);
    wait_idle();

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snitch_acc_issue.md
Name: snitch_acc_issue

Overview:
Core-side initiator for the shared accelerator (acc) request/response interface, the counterpart of the per-core shared-subsystem port that arbitrates requests and routes responses by ID. It accepts offload requests from the core, allocates a transaction ID, and drives the acc request channel. It matches out-of-order responses back to their destination register and presents them on a single writeback port, maintaining a destination-register busy mask for hazard checks.

Parameters:
DataWidth, 32, operand/result width
IdWidth, 5, acc ID width; IDs issued are 0..MaxOutstanding-1, zero-extended
MaxOutstanding, 4, tag-table entries; must satisfy 1 <= MaxOutstanding <= 2**IdWidth

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
off_valid_i / off_ready_o  in/out  1  core offload handshake
off_addr_i  in  32  accelerator select address
off_op_i  in  32  instruction word
off_arga_i, off_argb_i, off_argc_i  in  DataWidth  operands
off_rd_i  in  5  destination register
acc_qvalid_o / acc_qready_i  out/in  1  request handshake
acc_qaddr_o  out  32; acc_qid_o  out  IdWidth; acc_qdata_op_o  out  32
acc_qdata_arga_o, acc_qdata_argb_o, acc_qdata_argc_o  out  DataWidth  registered request
acc_pvalid_i / acc_pready_o  in/out  1  response handshake
acc_pid_i  in  IdWidth; acc_pdata_i  in  DataWidth; acc_perror_i  in  1  response payload
wb_valid_o / wb_ready_i  out/in  1  writeback handshake
wb_rd_o  out  5; wb_data_o  out  DataWidth; wb_error_o  out  1  writeback payload
rd_busy_o  out  32  bit r set while a writeback to xr is pending (bit 0 always 0)
outstanding_o  out  $clog2(MaxOutstanding+1)  valid table entries
idle_o  out  1  no valid entry, request stage empty, writeback stage empty
spurious_o  out  1  one-cycle pulse: response ID with no valid entry

Behaviour:
- Reset: acc_qvalid_o=0, wb_valid_o=0, all payload outputs 0, rd_busy_o=0, outstanding_o=0, spurious_o=0, idle_o=1, all entries invalid. Reset mid-transaction discards all state; late responses after reset report as spurious.
- Tag table: MaxOutstanding entries of {valid, rd}. Allocation picks the lowest-index invalid entry; acc_qid_o carries that index.
- off_ready_o = free entry exists AND (request stage empty OR acc_qready_i) AND NOT (off_rd_i!=0 AND rd_busy_o[off_rd_i]). The last term is a WAW stall; rd=0 never stalls.
- On an offload handshake at edge N: payload is registered, acc_qvalid_o=1 from cycle N+1, the entry is set valid with its rd, and rd_busy_o[rd] is set (unless rd=0).
- Request stage: acc_q* is stable while acc_qvalid_o && !acc_qready_i. A back-to-back issue is accepted in the same cycle as a drain (full throughput).
- Response stage: acc_pready_o = !wb_valid_o || wb_ready_i.
  - On a response handshake with a valid entry: the writeback stage loads {rd, data, error}; wb_valid_o=1 from the next cycle.
  - If the entry is invalid: the response is dropped, the wb stage is unchanged, and spurious_o pulses the next cycle.
- Entry release happens on the writeback handshake, not on response acceptance. That edge clears the entry's valid bit and rd_busy_o[rd]. Freed entries and cleared busy bits are visible to allocation one cycle later: no same-cycle reuse; a same-rd request stalls at least through the release cycle.
- Responses may arrive in any order; writeback order equals response-acceptance order.
- outstanding_o counts valid entries; it increments on issue and decrements on release, and is unchanged when both happen in the same cycle.
- acc_perror_i is passed through to wb_error_o; error responses free the entry normally.

Optional Feature:
SNITCH_ACC_ISSUE_PERF_EN: adds outputs perf_issued_o[31:0] (offload handshakes), perf_stall_o[31:0] (cycles with off_valid_i && !off_ready_o), and perf_spurious_o[15:0]. All are reset to 0, wrap modulo width, and are cleared synchronously by an added input perf_clear_i, with clear taking precedence over increment. Without the macro these ports and counters do not exist.

Test Plan:
- Single op: issue rd=5, arga=3, argb=4; the acc returns id 0, data 0x0000000C, 3 cycles later -> wb rd=5 data=0xC error=0; rd_busy_o[5] is set 1 cycle after issue and cleared after the wb handshake; idle_o returns to 1.
- Fill: MaxOutstanding=4, issue rd=1..4 with no responses -> IDs 0,1,2,3; 5th offload sees off_ready_o=0 until one wb handshake, then takes the freed ID one cycle later; outstanding_o peaks at 4.
- WAW: two back-to-back offloads with rd=7 -> second stalls until the cycle after the first wb handshake; rd=0 offloads never stall.
- Out-of-order: issue rd=10,11,12 (IDs 0,1,2); respond IDs 2,0,1 -> wb sequence rd=12,10,11 with matching data.
- Backpressure: acc_qready_i=0 for 5 cycles -> acc_q* held stable; wb_ready_i=0 with wb full -> acc_pready_o=0 and a second response is held until wb drains.
- Spurious/reset: response id 3 with no valid entry -> spurious_o single pulse, no wb; rst_ni asserted mid-flight -> all outputs at reset values, and a later response is flagged spurious.
